// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the serial 0110 pattern detector.
// PATTERN is listed first bit first (MSB is the earliest bit on the lane).
package seq_detect_pkg;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;

    localparam logic [3:0] PATTERN = 4'b0110;

endpackage

// File: rtl/seq_detect.sv
// Mealy detector for the overlapping serial pattern 0110.
// z is combinational from the state register and the live x bit.
module seq_detect
    import seq_detect_pkg::*;
(
    input  logic x,
    input  logic clk,
    input  logic reset,
    output logic z
);

    state_t     state_reg;
    state_t     state_next;
    logic [2:0] hist_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S0;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = S0;
        case (state_reg)
            S0:      state_next = x ? S0 : S1;
            S1:      state_next = x ? S2 : S1;
            S2:      state_next = x ? S3 : S1;
            // A completed match leaves its trailing 0 as the start of the next prefix.
            S3:      state_next = x ? S0 : S1;
            default: state_next = S0;
        endcase
    end

    assign z = (state_reg == S3) && !x && !reset;

    // Last three accepted bits, kept only so the assertion can cross-check z.
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_reg <= 3'b000;
        end else begin
            hist_reg <= {hist_reg[1:0], x};
        end
    end

    a_z_needs_prefix : assert property (
        @(posedge clk) disable iff (reset) z |-> (hist_reg == PATTERN[3:1])
    );

endmodule

// File: tb/tb_seq_detect.sv
// Randomized bench for seq_detect against a pattern-window reference model.
// The model keeps the accepted bits since reset and compares them with PATTERN.
module tb_seq_detect;
    import seq_detect_pkg::*;

    logic clk;
    logic reset;
    logic x;
    logic z;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    bit hist_q[$];

    seq_detect dut (
        .x     (x),
        .clk   (clk),
        .reset (reset),
        .z     (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Expected z: the bits accepted since reset, followed by the live bit, end in PATTERN.
    function automatic logic model_z(input logic b, input logic r);
        logic [3:0] win;
        int n;
        n = hist_q.size();
        if (r || n < 3) return 1'b0;
        win = {hist_q[n-3], hist_q[n-2], hist_q[n-1], b};
        return (win == PATTERN);
    endfunction

    function automatic void model_accept(input logic b, input logic r);
        if (r) begin
            hist_q.delete();
        end else begin
            hist_q.push_back(b);
            if (hist_q.size() > 3) void'(hist_q.pop_front());
        end
    endfunction

    // One bit per edge: drive just after an edge, check mid-cycle, then clock it in.
    task automatic step(input logic b, input logic r, input string tag);
        logic exp;
        reset = r;
        x     = b;
        #2;
        exp = model_z(b, r);
        check_val(tag, z, exp);
        if (z === 1'b1) pulses++;
        $display("tx %s x=%b reset=%b z=%b", tag, b, r, z);
        @(posedge clk);
        model_accept(b, r);
        #1;
    endtask

    task automatic run_seq(input logic [15:0] bits, input int n, input string tag,
                           input int exp_pulses);
        logic [15:0] v;
        v = bits;
        pulses = 0;
        for (int i = n - 1; i >= 0; i--) step(v[i], 1'b0, tag);
        check_int({tag, "_pulses"}, pulses, exp_pulses);
    endtask

    initial begin
        reset = 1'b1;
        x     = 1'b1;
        @(posedge clk);
        #1;

        // Reset with idle input, including an unknown x while reset is high.
        step(1'b1, 1'b1, "rst_idle");
        step(1'b1, 1'b1, "rst_idle");
        reset = 1'b1;
        x     = 1'bx;
        #2;
        check_val("rst_xin", z, 1'b0);
        @(posedge clk);
        model_accept(1'b0, 1'b1);
        #1;
        reset = 1'b0;

        run_seq(16'b00110, 5, "single", 1);
        step(1'b1, 1'b1, "rst");
        run_seq(16'b001101100110, 12, "overlap", 3);
        step(1'b1, 1'b1, "rst");
        run_seq(16'b01110, 5, "broken", 0);
        run_seq(16'b110, 3, "broken2", 1);
        run_seq(16'b0110, 4, "broken3", 1);
        step(1'b1, 1'b1, "rst");

        // Reset in the middle of a partial match discards the prefix.
        run_seq(16'b011, 3, "midrst", 0);
        step(1'b0, 1'b1, "midrst_rst");
        step(1'b0, 1'b0, "midrst_after");

        // Mealy path: in S3, z follows !x without any clock edge.
        step(1'b1, 1'b1, "rst");
        run_seq(16'b011, 3, "to_s3", 0);
        x = 1'b1; #1; check_val("mealy_x1", z, 1'b0);
        x = 1'b0; #1; check_val("mealy_x0", z, 1'b1);
        x = 1'b1; #1; check_val("mealy_x1b", z, 1'b0);
        @(posedge clk);
        model_accept(1'b1, 1'b0);
        #1;

        // Random bits with occasional resets.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(1, 0)), ($urandom_range(31, 0) == 0), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
